// File: rtl/object_transform.sv
// Object-phase stage: rotates, scales and translates each object's (x,y) into screen space.
// Result valid 3 cycles after the Y byte; holds until OUT_READY, STATUS=0 aborts to IDLE.
module object_transform #(
    parameter int OUT_W     = 16,
    parameter int ZOOM_FRAC = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    STATUS,
    input  logic                    FINISH,
    input  logic                    READING,
    input  logic [7:0]              RByt0,
    output logic                    RREADY,
    input  logic [7:0]              X_center,
    input  logic [7:0]              Y_center,
    input  logic [7:0]              Angle,
    input  logic [7:0]              Zoom,
    output logic                    NEXT,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic signed [OUT_W-1:0] OUT_X,
    output logic signed [OUT_W-1:0] OUT_Y,
    output logic                    OUT_ONSCREEN
);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_X, S_GET_Y, S_ROT, S_SCALE, S_EMIT, S_NXT, S_SYNC
    } state_t;

    state_t                    state_q, state_d;
    logic signed [7:0]         x_q, x_d, y_q, y_d;
    logic signed [9:0]         xr_q, xr_d, yr_q, yr_d;
    logic signed [OUT_W-1:0]   out_x_q, out_x_d, out_y_q, out_y_d;
    logic                      onscreen_q, onscreen_d;

    logic                      rready;
    logic signed [7:0]         sin_v, cos_v;
    logic signed [16:0]        sum_x, sum_y;
    logic signed [18:0]        prod_x, prod_y;
    logic signed [8:0]         zoom_s;

    // round(127*sin(2*pi*k/256)) for the first quarter turn
    function automatic logic [6:0] quarter_sin(input logic [6:0] k);
        case (k)
            7'd0:  return 7'd0;   7'd1:  return 7'd3;   7'd2:  return 7'd6;   7'd3:  return 7'd9;
            7'd4:  return 7'd12;  7'd5:  return 7'd16;  7'd6:  return 7'd19;  7'd7:  return 7'd22;
            7'd8:  return 7'd25;  7'd9:  return 7'd28;  7'd10: return 7'd31;  7'd11: return 7'd34;
            7'd12: return 7'd37;  7'd13: return 7'd40;  7'd14: return 7'd43;  7'd15: return 7'd46;
            7'd16: return 7'd49;  7'd17: return 7'd51;  7'd18: return 7'd54;  7'd19: return 7'd57;
            7'd20: return 7'd60;  7'd21: return 7'd63;  7'd22: return 7'd65;  7'd23: return 7'd68;
            7'd24: return 7'd71;  7'd25: return 7'd73;  7'd26: return 7'd76;  7'd27: return 7'd78;
            7'd28: return 7'd81;  7'd29: return 7'd83;  7'd30: return 7'd85;  7'd31: return 7'd88;
            7'd32: return 7'd90;  7'd33: return 7'd92;  7'd34: return 7'd94;  7'd35: return 7'd96;
            7'd36: return 7'd98;  7'd37: return 7'd100; 7'd38: return 7'd102; 7'd39: return 7'd104;
            7'd40: return 7'd106; 7'd41: return 7'd107; 7'd42: return 7'd109; 7'd43: return 7'd111;
            7'd44: return 7'd112; 7'd45: return 7'd113; 7'd46: return 7'd115; 7'd47: return 7'd116;
            7'd48: return 7'd117; 7'd49: return 7'd118; 7'd50: return 7'd120; 7'd51: return 7'd121;
            7'd52: return 7'd122; 7'd53: return 7'd122; 7'd54: return 7'd123; 7'd55: return 7'd124;
            7'd56: return 7'd125; 7'd57: return 7'd125; 7'd58: return 7'd126; 7'd59: return 7'd126;
            7'd60: return 7'd126; 7'd61: return 7'd127; 7'd62: return 7'd127; 7'd63: return 7'd127;
            default: return 7'd127;
        endcase
    endfunction

    // Angle[6] mirrors the quarter index, Angle[7] negates
    function automatic logic signed [7:0] sin8(input logic [7:0] a);
        logic [6:0] idx;
        logic [7:0] mag;
        idx = a[6] ? (7'd64 - {1'b0, a[5:0]}) : {1'b0, a[5:0]};
        mag = {1'b0, quarter_sin(idx)};
        return a[7] ? -$signed(mag) : $signed(mag);
    endfunction

    always_comb begin
        sin_v  = sin8(Angle);
        cos_v  = sin8(Angle + 8'd64);
        sum_x  = 17'(x_q) * 17'(cos_v) - 17'(y_q) * 17'(sin_v);
        sum_y  = 17'(x_q) * 17'(sin_v) + 17'(y_q) * 17'(cos_v);
        zoom_s = $signed({1'b0, Zoom});
        prod_x = 19'(xr_q) * 19'(zoom_s);
        prod_y = 19'(yr_q) * 19'(zoom_s);
    end

    assign rready = STATUS && ((state_q == S_GET_X) || (state_q == S_GET_Y));

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        xr_d       = xr_q;
        yr_d       = yr_q;
        out_x_d    = out_x_q;
        out_y_d    = out_y_q;
        onscreen_d = onscreen_q;
        case (state_q)
            S_IDLE:  if (STATUS && !FINISH) state_d = S_GET_X;
            S_GET_X: if (READING && rready) begin
                x_d     = $signed(RByt0);
                state_d = S_GET_Y;
            end
            S_GET_Y: if (READING && rready) begin
                y_d     = $signed(RByt0);
                state_d = S_ROT;
            end
            S_ROT: begin
                xr_d    = 10'(sum_x >>> 7);
                yr_d    = 10'(sum_y >>> 7);
                state_d = S_SCALE;
            end
            S_SCALE: begin
                out_x_d    = OUT_W'(prod_x >>> ZOOM_FRAC) + OUT_W'(X_center);
                out_y_d    = OUT_W'(prod_y >>> ZOOM_FRAC) + OUT_W'(Y_center);
                onscreen_d = (out_x_d[OUT_W-1:8] == '0) && (out_y_d[OUT_W-1:8] == '0);
                state_d    = S_EMIT;
            end
            S_EMIT:  if (OUT_READY) state_d = S_NXT;
            S_NXT:   state_d = S_SYNC;
            S_SYNC:  state_d = FINISH ? S_IDLE : S_GET_X;
            default: state_d = S_IDLE;
        endcase
        // Frame abort wins over everything, including a pending result
        if (!STATUS && (state_q != S_IDLE)) state_d = S_IDLE;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            xr_q       <= '0;
            yr_q       <= '0;
            out_x_q    <= '0;
            out_y_q    <= '0;
            onscreen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            xr_q       <= xr_d;
            yr_q       <= yr_d;
            out_x_q    <= out_x_d;
            out_y_q    <= out_y_d;
            onscreen_q <= onscreen_d;
        end
    end

    assign RREADY       = rready;
    assign NEXT         = (state_q == S_NXT);
    assign OUT_VALID    = (state_q == S_EMIT);
    assign OUT_X        = out_x_q;
    assign OUT_Y        = out_y_q;
    assign OUT_ONSCREEN = onscreen_q;

endmodule

// File: tb/tb_object_transform.sv
// Directed bench for object_transform with a small global-stage object counter model.
module tb_object_transform;
    localparam int OUT_W = 16;

    logic                    ACLK = 1'b0;
    logic                    ARESETn, STATUS, READING, OUT_READY;
    logic                    FINISH;
    logic [7:0]              RByt0, X_center, Y_center, Angle, Zoom;
    logic                    RREADY, NEXT, OUT_VALID, OUT_ONSCREEN;
    logic signed [OUT_W-1:0] OUT_X, OUT_Y;

    int n_checks = 0, n_fail = 0;
    int next_cnt = 0, base_cnt = 0, obj_total = 0;
    int seen, lat;

    object_transform #(.OUT_W(OUT_W), .ZOOM_FRAC(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .STATUS(STATUS), .FINISH(FINISH),
        .READING(READING), .RByt0(RByt0), .RREADY(RREADY),
        .X_center(X_center), .Y_center(Y_center), .Angle(Angle), .Zoom(Zoom),
        .NEXT(NEXT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT_X(OUT_X), .OUT_Y(OUT_Y), .OUT_ONSCREEN(OUT_ONSCREEN)
    );

    always #5 ACLK = ~ACLK;

    // Global stage: count drops on each NEXT, FINISH once the frame's objects are done
    always @(posedge ACLK) if (NEXT) next_cnt <= next_cnt + 1;
    assign FINISH = (next_cnt - base_cnt) >= obj_total;

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic start_frame(input int n);
        STATUS = 1'b0;
        @(negedge ACLK);
        base_cnt  = next_cnt;
        obj_total = n;
        STATUS    = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        READING = 1'b1;
        RByt0   = b;
        while (!RREADY && waited < 20) begin
            @(negedge ACLK);
            waited++;
        end
        check("byte_accept", int'(RREADY), 1);
        @(negedge ACLK);
        READING = 1'b0;
    endtask

    task automatic wait_valid(output int l);
        l = 1;
        while (!OUT_VALID && l < 20) begin
            @(negedge ACLK);
            l++;
        end
    endtask

    task automatic run_object(input logic [7:0] bx, input logic [7:0] by,
                              input int ex, input int ey, input int eon, input int stall);
        int l;
        send_byte(bx);
        send_byte(by);
        wait_valid(l);
        check("latency", l, 3);
        check("out_x", OUT_X, ex);
        check("out_y", OUT_Y, ey);
        check("onscreen", int'(OUT_ONSCREEN), eon);
        for (int i = 0; i < stall; i++) begin
            @(negedge ACLK);
            check("stall_valid", int'(OUT_VALID), 1);
            check("stall_x", OUT_X, ex);
            check("stall_y", OUT_Y, ey);
        end
        OUT_READY = 1'b1;
        @(negedge ACLK);
        OUT_READY = 1'b0;
        check("next_pulse", int'(NEXT), 1);
        check("valid_drop", int'(OUT_VALID), 0);
        @(negedge ACLK);
        check("next_single", int'(NEXT), 0);
    endtask

    initial begin
        ARESETn = 1'b0; STATUS = 1'b0; READING = 1'b0; RByt0 = '0; OUT_READY = 1'b0;
        X_center = 8'd100; Y_center = 8'd50; Angle = 8'd0; Zoom = 8'h10;
        #12;
        check("rst_rready", int'(RREADY), 0);
        check("rst_next", int'(NEXT), 0);
        check("rst_valid", int'(OUT_VALID), 0);
        check("rst_x", OUT_X, 0);
        check("rst_y", OUT_Y, 0);
        check("rst_onscreen", int'(OUT_ONSCREEN), 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        @(negedge ACLK);

        // Identity rotation, truncation toward minus infinity
        start_frame(1);
        run_object(8'h0A, 8'hFB, 109, 45, 1, 0);
        @(negedge ACLK);
        check("idle_rready", int'(RREADY), 0);

        // Rotation through each quadrant plus the 45-degree table point
        Angle = 8'd64;  start_frame(1); run_object(8'h0A, 8'h00, 100, 59, 1, 0);
        Angle = 8'd32;  start_frame(1); run_object(8'h0A, 8'h00, 107, 57, 1, 0);
        Angle = 8'd128; start_frame(1); run_object(8'h0A, 8'h00, 90, 50, 1, 0);
        Angle = 8'd192; start_frame(1); run_object(8'h0A, 8'h00, 100, 40, 1, 0);

        // Extreme inputs at zoom 2.0 land off-screen
        Angle = 8'd0; Zoom = 8'h20;
        start_frame(1); run_object(8'h80, 8'h7F, -154, 302, 0, 0);
        Zoom = 8'h10;

        // Three objects, stall on the second
        start_frame(3);
        run_object(8'h0A, 8'hFB, 109, 45, 1, 0);
        run_object(8'h00, 8'h00, 100, 50, 1, 5);
        run_object(8'hF6, 8'h05, 90, 54, 1, 0);
        check("next_count3", next_cnt - base_cnt, 3);
        seen = 0;
        repeat (4) begin
            @(negedge ACLK);
            if (RREADY) seen++;
        end
        check("idle_after_3", seen, 0);

        // Zero objects
        start_frame(0);
        seen = 0;
        repeat (8) begin
            @(negedge ACLK);
            if (RREADY || OUT_VALID || NEXT) seen++;
        end
        check("zero_obj_activity", seen, 0);

        // Abort after the X byte, then restart with a fresh X
        start_frame(1);
        send_byte(8'h0A);
        STATUS = 1'b0;
        @(negedge ACLK);
        STATUS = 1'b1;
        #1;
        check("abort_idle", int'(RREADY), 0);
        check("abort_valid", int'(OUT_VALID), 0);
        check("abort_no_next", next_cnt - base_cnt, 0);
        run_object(8'h14, 8'h00, 119, 50, 1, 0);

        // Asynchronous reset while a result is pending
        start_frame(1);
        send_byte(8'h0A);
        send_byte(8'hFB);
        wait_valid(lat);
        check("rst_pre_valid", int'(OUT_VALID), 1);
        #1 ARESETn = 1'b0;
        #1;
        check("arst_valid", int'(OUT_VALID), 0);
        check("arst_x", OUT_X, 0);
        check("arst_y", OUT_Y, 0);
        check("arst_onscreen", int'(OUT_ONSCREEN), 0);
        check("arst_rready", int'(RREADY), 0);
        @(negedge ACLK);
        ARESETn = 1'b1;
        check("arst_no_next", next_cnt - base_cnt, 0);
        run_object(8'h0A, 8'hFB, 109, 45, 1, 0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
